// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: one word per start/ready handshake, internal bit-period counter.
// Optional break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_param #(
  parameter int unsigned BAUDRATE  = 104,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 tx,
  input  logic                 brk
);

  if (BAUDRATE < 2 || BAUDRATE > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
    $error("uart_tx_param: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK,
    S_BRKEND
`endif
  } state_t;

  state_t               state, state_n;
  logic [15:0]          cnt, cnt_n;
  logic [3:0]           idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 par, par_n;
  logic                 tx_n;
  logic                 last;

  assign last = (cnt == 16'(BAUDRATE - 1));

`ifdef UART_TX_BREAK_EN
  // brk gates ready so a simultaneous start is never accepted while a break is requested
  assign ready = (state == S_IDLE) && !brk;
`else
  logic unused_brk;
  assign unused_brk = brk;
  assign ready = (state == S_IDLE);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      par   <= par_n;
      tx    <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = last ? '0 : cnt + 16'd1;
    idx_n   = idx;
    sh_n    = sh;
    par_n   = par;
    tx_n    = tx;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        tx_n  = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (brk) begin
          state_n = S_BREAK;
          tx_n    = 1'b0;
        end else
`endif
        if (start) begin
          state_n = S_START;
          sh_n    = data;
          par_n   = (PARITY == 1) ? ~^data : ^data;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (last) begin
          state_n = S_DATA;
          idx_n   = '0;
          tx_n    = sh[0];
        end
      end
      S_DATA: begin
        if (last) begin
          if (idx == 4'(DATA_BITS - 1)) begin
            idx_n = '0;
            if (PARITY != 0) begin
              state_n = S_PARITY;
              tx_n    = par;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n = idx + 4'd1;
            sh_n  = sh >> 1;
            tx_n  = sh[1];
          end
        end
      end
      S_PARITY: begin
        if (last) begin
          state_n = S_STOP;
          idx_n   = '0;
          tx_n    = 1'b1;
        end
      end
      S_STOP: begin
        tx_n = 1'b1;
        if (last) begin
          if (idx == 4'(STOP_BITS - 1)) begin
            state_n = S_IDLE;
            idx_n   = '0;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        cnt_n = '0;
        tx_n  = 1'b0;
        if (!brk) begin
          state_n = S_BRKEND;
          tx_n    = 1'b1;
        end
      end
      S_BRKEND: begin
        tx_n = 1'b1;
        if (last) state_n = S_IDLE;
      end
`endif
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four instances (8N1, 8E1, 8O1, 7N2) at BAUDRATE=4.
// Expected per-clock tx values are queued at accept time and popped while the frame is sampled.
module tb_uart_tx_param;

  localparam int B = 4;
  localparam int DB[4]   = '{8, 8, 8, 7};
  localparam int HASP[4] = '{0, 1, 1, 0};
  localparam int SB[4]   = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       brk = 1'b0;
  logic [3:0] start_v = '0;
  logic [8:0] data_v [4];
  logic [3:0] ready_v, tx_v;

  int ntests = 0;
  int nfail  = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_param #(.BAUDRATE(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rstn(rstn), .start(start_v[0]), .data(data_v[0][7:0]),
    .ready(ready_v[0]), .tx(tx_v[0]), .brk(brk));
  uart_tx_param #(.BAUDRATE(B), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rstn(rstn), .start(start_v[1]), .data(data_v[1][7:0]),
    .ready(ready_v[1]), .tx(tx_v[1]), .brk(brk));
  uart_tx_param #(.BAUDRATE(B), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rstn(rstn), .start(start_v[2]), .data(data_v[2][7:0]),
    .ready(ready_v[2]), .tx(tx_v[2]), .brk(brk));
  uart_tx_param #(.BAUDRATE(B), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rstn(rstn), .start(start_v[3]), .data(data_v[3][6:0]),
    .ready(ready_v[3]), .tx(tx_v[3]), .brk(brk));

  typedef struct {
    int         dut;
    logic [8:0] dat;
    logic       par;
    int         len;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic push_bit(input logic v);
    for (int c = 0; c < B; c++) exp_q.push_back(v);
  endtask

  task automatic push_frame(input int d, input logic [8:0] dat, input logic par);
    push_bit(1'b0);
    for (int i = 0; i < DB[d]; i++) push_bit(dat[i]);
    if (HASP[d] != 0) push_bit(par);
    for (int s = 0; s < SB[d]; s++) push_bit(1'b1);
  endtask

  // drive start across one edge, leave the sample point just after it
  task automatic accept(input int d, input logic [8:0] dat);
    @(negedge clk);
    start_v[d] = 1'b1;
    data_v[d]  = dat;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int d, input int len, input int poke, input bit hold);
    int   lowcnt;
    logic e;
    lowcnt = 0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      chk("frame_tx", 32'(tx_v[d]), 32'(e));
      if (!ready_v[d]) lowcnt++;
      start_v[d] = hold || (i == poke);
      if (i == poke) data_v[d] = 9'h1FF;
      @(posedge clk);
      #1;
    end
    chk("ready_low_len", 32'(lowcnt), 32'(len));
    chk("idle_tx", 32'(tx_v[d]), 32'd1);
    chk("idle_ready", 32'(ready_v[d]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) data_v[i] = '0;
    vt[0] = '{dut: 0, dat: 9'h055, par: 1'b0, len: 40};
    vt[1] = '{dut: 1, dat: 9'h007, par: 1'b1, len: 44};
    vt[2] = '{dut: 2, dat: 9'h007, par: 1'b0, len: 44};
    vt[3] = '{dut: 3, dat: 9'h07F, par: 1'b0, len: 40};
    vt[4] = '{dut: 1, dat: 9'h0A3, par: 1'b0, len: 44};
    vt[5] = '{dut: 2, dat: 9'h0A3, par: 1'b1, len: 44};
    vt[6] = '{dut: 0, dat: 9'h000, par: 1'b0, len: 40};

    repeat (6) @(posedge clk);
    #1;
    chk("reset_tx", 32'(tx_v), 32'hF);
    chk("reset_ready", 32'(ready_v), 32'hF);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      accept(vt[i].dut, vt[i].dat);
      push_frame(vt[i].dut, vt[i].dat, vt[i].par);
      drain(vt[i].dut, vt[i].len, -1, 1'b0);
    end

    // back-to-back with start held: second start bit one clk after ready returns
    accept(3, 9'h07F);
    push_frame(3, 9'h07F, 1'b0);
    drain(3, 40, -1, 1'b1);
    data_v[3] = 9'h02A;
    @(posedge clk);
    #1;
    push_frame(3, 9'h02A, 1'b0);
    drain(3, 40, -1, 1'b0);

    // busy ignore: start with 0xFF at clk 10 must not disturb the 0xA5 frame
    accept(0, 9'h0A5);
    push_frame(0, 9'h0A5, 1'b0);
    drain(0, 40, 10, 1'b0);
    for (int i = 0; i < 2 * B * 10; i++) begin
      @(posedge clk);
      #1;
      chk("no_second_frame", 32'({tx_v[0], ready_v[0]}), 32'h3);
    end

    // asynchronous reset mid-frame
    accept(0, 9'h000);
    push_frame(0, 9'h000, 1'b0);
    for (int i = 0; i < 15; i++) begin
      chk("pre_reset_tx", 32'(tx_v[0]), 32'(exp_q.pop_front()));
      start_v[0] = 1'b0;
      @(posedge clk);
      #1;
    end
    exp_q.delete();
    #2;
    rstn = 1'b0;
    #1;
    chk("async_reset_tx", 32'(tx_v[0]), 32'd1);
    chk("async_reset_ready", 32'(ready_v[0]), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_idle", 32'({tx_v[0], ready_v[0]}), 32'h3);
    accept(0, 9'h000);
    push_frame(0, 9'h000, 1'b0);
    drain(0, 40, -1, 1'b0);

    // break request while idle
    @(negedge clk);
    brk = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
`ifdef UART_TX_BREAK_EN
      chk("break_low", 32'({tx_v[0], ready_v[0]}), 32'h0);
`else
      chk("brk_ignored", 32'({tx_v[0], ready_v[0]}), 32'h3);
`endif
    end
    @(negedge clk);
    brk = 1'b0;
    for (int i = 0; i < B; i++) begin
      @(posedge clk);
      #1;
`ifdef UART_TX_BREAK_EN
      chk("break_recover", 32'({tx_v[0], ready_v[0]}), 32'h2);
`else
      chk("brk_ignored_tail", 32'({tx_v[0], ready_v[0]}), 32'h3);
`endif
    end
    @(posedge clk);
    #1;
    chk("after_break_idle", 32'({tx_v[0], ready_v[0]}), 32'h3);
    accept(0, 9'h0C3);
    push_frame(0, 9'h0C3, 1'b0);
    drain(0, 40, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed-format character transmitter. It serialises one word per valid/ready handshake, with configurable data width, parity and stop bits. It sits between the user logic and the board tx pin, and is driven by the baud divisor values already used for the baudgen constants (`B115200 etc.). The bit-period counter is internal, so no separate baudgen instance is needed.

Parameters:
BAUDRATE, 104 (`B115200 at 12 MHz), clock cycles per serial bit; legal range 2..65535
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame; legal values 1 or 2

Ports:
clk  input  1  system clock
rstn  input  1  reset; asynchronous, active-low
start  input  1  request to transmit data; qualified by ready
data  input  DATA_BITS  word to send; sampled only on accept
ready  output  1  high when idle and able to accept
tx  output  1  serial line; idle high
brk  input  1  break request; used only with UART_TX_BREAK_EN

Behaviour:
- Reset (rstn=0, asynchronous): tx=1, ready=1, state IDLE, baud counter=0, shift register=0. Takes effect immediately, including mid-frame; the frame is aborted and nothing is resumed after rstn rises.
- Definitions: N = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS. Accept = start & ready at a rising clk edge.
- On accept at edge k:
  - data latched; parity computed from the latched word (odd: total ones incl. parity bit is odd; even: even).
  - State goes to START and the baud counter clears.
  - ready=0 and tx=0 from edge k.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
- Every bit is held for exactly BAUDRATE cycles. The counter runs 0..BAUDRATE-1; at terminal count the next bit is driven.
- DATA is sent LSB first, bit index 0..DATA_BITS-1. STOP drives 1 for STOP_BITS*BAUDRATE cycles.
- At edge k+N*BAUDRATE: state=IDLE, ready=1, tx=1.
- The earliest next accept is edge k+N*BAUDRATE+1, so back-to-back frames have exactly one clk of extra idle-high between them.
- start while ready=0 is ignored. data is not re-sampled, and the in-flight frame is unaffected.
- Changes on data after accept have no effect on the current frame.
- tx is driven from a register (glitch-free). ready is combinational from state==IDLE plus break gating.
- Out-of-range parameters are caught by a generate-time check that calls $error.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined:
  - brk=1 sampled while IDLE enters state BREAK: tx=0, ready=0, held as long as brk=1.
  - When brk falls, the block drives tx=1 for one full bit period (BAUDRATE cycles) and then returns to IDLE with ready=1.
  - brk asserted mid-frame is deferred until the frame completes.
- Undefined: the brk port still exists but is ignored. The BREAK state and its logic are not synthesised.

Test Plan:
- BAUDRATE=4, 8N1: rstn low 6 clk, then start=1 for 1 clk with data=0x55 -> tx = 0,1,0,1,0,1,0,1,0,1, each held 4 clk. ready low exactly 40 clk, then high with tx=1.
- BAUDRATE=4, PARITY=2, data=0x07 -> parity bit=1. The same run with PARITY=1 -> parity bit=0. ready low 44 clk.
- DATA_BITS=7, STOP_BITS=2, data=0x7F -> start bit, seven 1s, then stop high for 8 clk. Frame length 40 clk; start held continuously gives the next start bit 41 clk after the first.
- Busy ignore: accept 0xA5, then pulse start with data=0xFF at clk 10 -> the frame still carries 0xA5 (LSB first 1,0,1,0,0,1,0,1) and no second frame is sent.
- Reset mid-frame: drop rstn at clk 15 of a 40-clk frame -> tx=1 and ready=1 in the same cycle with no clk edge. After release, a new accept of 0x00 sends a correct full frame.
- UART_TX_BREAK_EN defined: brk=1 for 30 clk while idle -> tx=0 and ready=0 for 30 clk, then tx=1 for 4 clk, then ready=1.
